// File: rtl/dtm_dmi_master_pkg.sv
// Shared DMI/DBUS encodings, field widths and DM register addresses for the debug transport.
package dtm_dmi_master_pkg;

  localparam int unsigned DBUS_OP_WIDTH   = 2;
  localparam int unsigned DBUS_ADDR_WIDTH = 7;
  localparam int unsigned DBUS_DATA_WIDTH = 32;

  localparam logic [1:0] DMI_OP_NOP = 2'd0;
  localparam logic [1:0] DMI_OP_RD  = 2'd1;
  localparam logic [1:0] DMI_OP_WR  = 2'd2;

  localparam logic [1:0] DMI_STATUS_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_STATUS_FAILED  = 2'd2;
  localparam logic [1:0] DMI_STATUS_BUSY    = 2'd3;

  localparam logic [6:0] DM_DATA0      = 7'h04;
  localparam logic [6:0] DM_DMCONTROL  = 7'h10;
  localparam logic [6:0] DM_DMSTATUS   = 7'h11;
  localparam logic [6:0] DM_ABSTRACTCS = 7'h16;
  localparam logic [6:0] DM_COMMAND    = 7'h17;

  typedef enum logic [1:0] {
    DMI_IDLE,
    DMI_REQ,
    DMI_WAIT,
    DMI_DONE
  } dmi_state_e;

endpackage

// File: rtl/dmi_timeout_cnt.sv
// Saturating cycle counter bounding how long a DMI transaction may stall on the DM.
module dmi_timeout_cnt #(
  parameter int unsigned MAX = 1023
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != W'(MAX)) begin
      count <= count + W'(1);
    end
  end

  // Flags the cycle whose increment reaches MAX, so a phase lasts at most MAX cycles.
  assign expired = en && (count >= W'(MAX - 1));

endmodule

// File: rtl/dtm_dmi_master.sv
// DTM-side DMI master: one access at a time from the TAP to the DM, with sticky busy/failed status.
module dtm_dmi_master
  import dtm_dmi_master_pkg::*;
#(
  parameter int unsigned           OP_WIDTH   = DBUS_OP_WIDTH,
  parameter int unsigned           ADDR_WIDTH = DBUS_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = DBUS_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] CMD_ADDR   = DM_COMMAND,
  parameter int unsigned           TIMEOUT    = 1023
) (
  input  logic                                     sys_clk,
  input  logic                                     sys_rst,
  input  logic                                     dmi_access_valid,
  input  logic [OP_WIDTH-1:0]                      dmi_access_op,
  input  logic [ADDR_WIDTH-1:0]                    dmi_access_addr,
  input  logic [DATA_WIDTH-1:0]                    dmi_access_data,
  input  logic                                     dmi_reset,
  input  logic                                     dmi_hard_reset,
  output logic                                     dmi_busy,
  output logic                                     dmi_done,
  output logic [DATA_WIDTH-1:0]                    dmi_rdata,
  output logic [1:0]                               dmi_status,
  output logic                                     dtm_req_valid,
  input  logic                                     dtm_req_ready,
  output logic [OP_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] dtm_req_bits,
  input  logic                                     dm_resp_valid,
  output logic                                     dm_resp_ready,
  input  logic [OP_WIDTH+DATA_WIDTH-1:0]           dm_resp_bits
);

  localparam int unsigned REQ_W = OP_WIDTH + ADDR_WIDTH + DATA_WIDTH;

  dmi_state_e            state;
  logic [REQ_W-1:0]      req_q;
  logic [OP_WIDTH-1:0]   req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [OP_WIDTH-1:0]   resp_op;
  logic                  acc_is_bus;
  logic                  req_waits;
  logic                  in_flight;
  logic                  cnt_clr;
  logic                  tmo_hit;

  assign req_op     = req_q[OP_WIDTH-1:0];
  assign req_addr   = req_q[OP_WIDTH +: ADDR_WIDTH];
  assign resp_op    = dm_resp_bits[DATA_WIDTH +: OP_WIDTH];
  assign acc_is_bus = (dmi_access_op == OP_WIDTH'(DMI_OP_RD)) ||
                      (dmi_access_op == OP_WIDTH'(DMI_OP_WR));
  assign req_waits  = (req_op == OP_WIDTH'(DMI_OP_RD)) ||
                      ((req_op == OP_WIDTH'(DMI_OP_WR)) && (req_addr == CMD_ADDR));
  assign in_flight  = (state == DMI_REQ) || (state == DMI_WAIT);
  // Restart the budget for the response phase once the request handshakes.
  assign cnt_clr    = dmi_hard_reset || !in_flight || ((state == DMI_REQ) && dtm_req_ready);
  assign dtm_req_bits = req_q;

  dmi_timeout_cnt #(
    .MAX (TIMEOUT)
  ) u_timeout (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (cnt_clr),
    .en      (in_flight),
    .expired (tmo_hit)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= DMI_IDLE;
      req_q         <= '0;
      dmi_busy      <= 1'b0;
      dmi_done      <= 1'b0;
      dmi_rdata     <= '0;
      dmi_status    <= DMI_STATUS_SUCCESS;
      dtm_req_valid <= 1'b0;
      dm_resp_ready <= 1'b0;
    end else if (dmi_hard_reset) begin
      state         <= DMI_IDLE;
      dmi_busy      <= 1'b0;
      dmi_done      <= 1'b0;
      dmi_status    <= DMI_STATUS_SUCCESS;
      dtm_req_valid <= 1'b0;
      dm_resp_ready <= 1'b1;
    end else begin
      dmi_done <= 1'b0;
      case (state)
        DMI_IDLE: begin
          if (dmi_access_valid && (dmi_status == DMI_STATUS_SUCCESS || dmi_reset)) begin
            req_q         <= {dmi_access_data, dmi_access_addr, dmi_access_op};
            dm_resp_ready <= 1'b0;
            if (acc_is_bus) begin
              state         <= DMI_REQ;
              dmi_busy      <= 1'b1;
              dtm_req_valid <= 1'b1;
            end else begin
              state    <= DMI_DONE;
              dmi_done <= 1'b1;
            end
          end else begin
            dm_resp_ready <= 1'b1;
          end
        end
        DMI_REQ: begin
          if (dtm_req_ready) begin
            dtm_req_valid <= 1'b0;
            if (req_waits) begin
              state         <= DMI_WAIT;
              dm_resp_ready <= 1'b1;
            end else begin
              state    <= DMI_DONE;
              dmi_busy <= 1'b0;
              dmi_done <= 1'b1;
            end
          end else if (tmo_hit) begin
            dtm_req_valid <= 1'b0;
            dmi_status    <= DMI_STATUS_FAILED;
            state         <= DMI_DONE;
            dmi_busy      <= 1'b0;
            dmi_done      <= 1'b1;
          end
        end
        DMI_WAIT: begin
          if (dm_resp_valid) begin
            dm_resp_ready <= 1'b0;
            state         <= DMI_DONE;
            dmi_busy      <= 1'b0;
            dmi_done      <= 1'b1;
            if (req_op == OP_WIDTH'(DMI_OP_RD)) dmi_rdata <= dm_resp_bits[DATA_WIDTH-1:0];
            if (resp_op == OP_WIDTH'(DMI_STATUS_FAILED)) dmi_status <= DMI_STATUS_FAILED;
          end else if (tmo_hit) begin
            dm_resp_ready <= 1'b0;
            dmi_status    <= DMI_STATUS_FAILED;
            state         <= DMI_DONE;
            dmi_busy      <= 1'b0;
            dmi_done      <= 1'b1;
          end
        end
        DMI_DONE: begin
          state         <= DMI_IDLE;
          dm_resp_ready <= 1'b1;
        end
        default: state <= DMI_IDLE;
      endcase
      // Later assignments take priority: busy overrides failed, dmireset overrides both.
      if (dmi_access_valid && state != DMI_IDLE) dmi_status <= DMI_STATUS_BUSY;
      if (dmi_reset) dmi_status <= DMI_STATUS_SUCCESS;
    end
  end

endmodule
